fx_mac_pipe: RTL and testbench
==============================

Name: fx_mac_pipe

Overview:
Parametrised, pipelined signed fixed-point multiply-add/subtract unit. It is the next generation of the team's 8/16-bit adder and multiplier blocks used in the Y/Cr colour-conversion datapath.
Computes sat((A*B) >>> FRAC ± C) with a valid/ready handshake, per-stage stall with bubble collapsing, and a saturation flag.
Sits between the pixel-component source and the conversion output register.

Parameters:
IN_W, 16, width of signed operands a and b
FRAC, 8, number of fractional bits in a, b, c and result (0 < FRAC < IN_W)
OUT_W, 16, width of signed operand c and of the result

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts input this cycle
in_a  input  IN_W  signed multiplicand
in_b  input  IN_W  signed multiplier
in_c  input  OUT_W  signed addend
in_sub  input  1  0: product + c; 1: product - c
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  OUT_W  signed saturated result
out_sat  output  1  result was clamped

Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset: when rst=1 at a clk edge, all stage valid bits clear.
  - out_valid=0, out_result=0, out_sat=0 from the next cycle.
  - in_ready=1 while rst=0 and the pipeline is empty.
  - Reset mid-operation discards all in-flight beats; no partial output.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Held data must stay stable while out_valid=1 and out_ready=0.
- Stages:
  - S1: register a, b, c, sub.
  - S2: register the full signed product P = a*b (2*IN_W bits), plus c and sub.
  - S3: form Q = P >>> FRAC (arithmetic).
    - Sign-extend Q and c to max(2*IN_W, OUT_W)+2 bits.
    - Compute S = Q + c, or S = Q - c when sub=1.
    - Saturate S to OUT_W signed: S > 2^(OUT_W-1)-1 gives max; S < -2^(OUT_W-1) gives min; out_sat=1 when clamped, else 0.
    - Register the result into the output stage.
- Latency: exactly 3 cycles from input transfer to out_valid with no stalls. Throughput is 1 beat/cycle.
- Stall and bubble collapse:
  - Stage k advances when it is valid and (stage k+1 is empty or stage k+1 advances).
  - The output stage advances on out_ready.
  - in_ready = !v1 | adv1, combinational from out_ready via the advance chain.
  - A stalled pipeline holds up to 3 beats.
  - Empty stages fill while downstream is stalled.
- Simultaneous input transfer and output transfer in the same cycle: both occur; no beat is lost or duplicated.
- Beats leave in acceptance order.
- Ignored inputs: in_a/in_b/in_c/in_sub are don't-care when in_valid=0. out_result/out_sat are don't-care when out_valid=0, but hold their last values.
- No internal state beyond the pipeline registers. No FSM beyond the stage valid bits.

Optional Feature:
- Macro: FX_MAC_ROUND_EN.
- Defined: S3 adds 2^(FRAC-1) to P before the arithmetic shift (round half up toward +inf).
  - The rounding add is performed at full width, so it cannot overflow before saturation.
- Undefined: plain truncation (floor) via the arithmetic shift.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic add (defaults): a=0x0100, b=0x0200, c=0x0080, sub=0 → after exactly 3 cycles out_result=0x0280, out_sat=0.
- Subtract: a=0x0100, b=0x0100, c=0x0200, sub=1 → out_result=0xFF00 (-1.0), out_sat=0.
- Saturation:
  - a=0x7FFF, b=0x7FFF, c=0 → out_result=0x7FFF, out_sat=1.
  - a=0x8000, b=0x7FFF, c=0 → out_result=0x8000, out_sat=1.
- Rounding: a=0x0001, b=0x0080, c=0 → out_result=0x0000 without FX_MAC_ROUND_EN, 0x0001 with it.
- Backpressure: hold out_ready=0 and offer 4 beats (results 1, 2, 3, 4).
  - in_ready drops after the 3rd beat is accepted.
  - Raise out_ready: results arrive 1, 2, 3, then 4, in order, with no loss or duplicates.
  - Random out_ready toggling against a scoreboard gives matching results.
- Reset mid-flight: assert rst for 1 cycle with 2 beats in flight → out_valid=0 the next cycle, no stale result ever appears, and in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/fx_mac_pipe.sv
// fx_mac_pipe: three-stage signed fixed-point multiply-add/subtract with
// valid/ready flow control, per-stage stall with bubble collapsing, and
// saturation to OUT_W bits.
//   result = sat((a*b) >>> FRAC +/- c)
// Optional build macro: FX_MAC_ROUND_EN. When defined, 2^(FRAC-1) is added to
// the product before the arithmetic shift (round half up); otherwise the shift
// truncates toward -inf.
module fx_mac_pipe #(
    parameter int IN_W  = 16,
    parameter int FRAC  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    input  logic [OUT_W-1:0] in_c,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_result,
    output logic             out_sat
);

    // Full product width and the guarded sum width (two extra bits so that
    // Q +/- c can never wrap before the saturation compare).
    localparam int PW = 2 * IN_W;
    localparam int SW = ((PW > OUT_W) ? PW : OUT_W) + 2;

    localparam logic signed [SW-1:0] MAX_C = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_C = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef FX_MAC_ROUND_EN
    localparam logic signed [SW-1:0] RND_C = {{(SW-1){1'b0}}, 1'b1} << (FRAC-1);
`endif

    // Stage 1: captured operands
    logic                    v1_q,   v1_d;
    logic signed [IN_W-1:0]  a1_q,   a1_d;
    logic signed [IN_W-1:0]  b1_q,   b1_d;
    logic signed [OUT_W-1:0] c1_q,   c1_d;
    logic                    sub1_q, sub1_d;

    // Stage 2: full product plus carried addend
    logic                    v2_q,   v2_d;
    logic signed [PW-1:0]    p2_q,   p2_d;
    logic signed [OUT_W-1:0] c2_q,   c2_d;
    logic                    sub2_q, sub2_d;

    // Output stage
    logic                    v3_q,   v3_d;
    logic [OUT_W-1:0]        res_q,  res_d;
    logic                    sat_q,  sat_d;

    // Handshake / advance chain
    logic adv1_s, adv2_s, adv3_s, load1_s, in_ready_s;

    // Datapath intermediates
    logic signed [PW-1:0]    a_ext_s, b_ext_s, prod_s;
    logic signed [SW-1:0]    p_ext_s, p_rnd_s, q_s, c_ext_s, sum_s;
    logic [OUT_W-1:0]        sat_res_s;
    logic                    sat_flag_s;

    // Advance chain: a stage moves when it is full and its successor is empty or moving.
    always_comb begin
        adv3_s     = v3_q & out_ready;
        adv2_s     = v2_q & (~v3_q | adv3_s);
        adv1_s     = v1_q & (~v2_q | adv2_s);
        in_ready_s = ~v1_q | adv1_s;
        load1_s    = in_valid & in_ready_s;
    end

    // Stage 2 multiply: operands sign-extended to the product width.
    always_comb begin
        a_ext_s = {{IN_W{a1_q[IN_W-1]}}, a1_q};
        b_ext_s = {{IN_W{b1_q[IN_W-1]}}, b1_q};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Stage 3 arithmetic: optional round, shift, add/sub, then clamp.
    always_comb begin
        p_ext_s = {{(SW-PW){p2_q[PW-1]}}, p2_q};
`ifdef FX_MAC_ROUND_EN
        p_rnd_s = p_ext_s + RND_C;
`else
        p_rnd_s = p_ext_s;
`endif
        q_s     = p_rnd_s >>> FRAC;
        c_ext_s = {{(SW-OUT_W){c2_q[OUT_W-1]}}, c2_q};
        if (sub2_q) begin
            sum_s = q_s - c_ext_s;
        end else begin
            sum_s = q_s + c_ext_s;
        end
        if (sum_s > MAX_C) begin
            sat_res_s  = MAX_C[OUT_W-1:0];
            sat_flag_s = 1'b1;
        end else if (sum_s < MIN_C) begin
            sat_res_s  = MIN_C[OUT_W-1:0];
            sat_flag_s = 1'b1;
        end else begin
            sat_res_s  = sum_s[OUT_W-1:0];
            sat_flag_s = 1'b0;
        end
    end

    // Next-state for stage 1: fill on input transfer, empty when it drains, else hold.
    always_comb begin
        if (load1_s) begin
            v1_d = 1'b1;
        end else if (adv1_s) begin
            v1_d = 1'b0;
        end else begin
            v1_d = v1_q;
        end
        if (load1_s) begin
            a1_d   = in_a;
            b1_d   = in_b;
            c1_d   = in_c;
            sub1_d = in_sub;
        end else begin
            a1_d   = a1_q;
            b1_d   = b1_q;
            c1_d   = c1_q;
            sub1_d = sub1_q;
        end
    end

    // Next-state for stage 2: load the product when stage 1 advances.
    always_comb begin
        if (adv1_s) begin
            v2_d = 1'b1;
        end else if (adv2_s) begin
            v2_d = 1'b0;
        end else begin
            v2_d = v2_q;
        end
        if (adv1_s) begin
            p2_d   = prod_s;
            c2_d   = c1_q;
            sub2_d = sub1_q;
        end else begin
            p2_d   = p2_q;
            c2_d   = c2_q;
            sub2_d = sub2_q;
        end
    end

    // Next-state for the output stage: result/flag hold their last value when idle.
    always_comb begin
        if (adv2_s) begin
            v3_d = 1'b1;
        end else if (adv3_s) begin
            v3_d = 1'b0;
        end else begin
            v3_d = v3_q;
        end
        if (adv2_s) begin
            res_d = sat_res_s;
            sat_d = sat_flag_s;
        end else begin
            res_d = res_q;
            sat_d = sat_q;
        end
    end

    // Pipeline registers; reset drops every in-flight beat and clears the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            a1_q   <= {IN_W{1'b0}};
            b1_q   <= {IN_W{1'b0}};
            c1_q   <= {OUT_W{1'b0}};
            sub1_q <= 1'b0;
            v2_q   <= 1'b0;
            p2_q   <= {PW{1'b0}};
            c2_q   <= {OUT_W{1'b0}};
            sub2_q <= 1'b0;
            v3_q   <= 1'b0;
            res_q  <= {OUT_W{1'b0}};
            sat_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            c1_q   <= c1_d;
            sub1_q <= sub1_d;
            v2_q   <= v2_d;
            p2_q   <= p2_d;
            c2_q   <= c2_d;
            sub2_q <= sub2_d;
            v3_q   <= v3_d;
            res_q  <= res_d;
            sat_q  <= sat_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = v3_q;
    assign out_result = res_q;
    assign out_sat    = sat_q;

endmodule

// File: tb/tb_fx_mac_pipe.sv
// Directed bench for fx_mac_pipe (default parameters). Expected values are
// hand-computed constants plus a small saturating add/sub model for the
// randomised backpressure section.
module tb_fx_mac_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_c;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_sat;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_q[$];
    logic [16:0] exp_v;
    logic        hold_pend;
    logic [15:0] hold_val;

    fx_mac_pipe #(.IN_W(16), .FRAC(8), .OUT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sat    (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent model for a = 1.0 (0x0100): Q equals b exactly in both builds.
    function automatic logic [16:0] model(input logic [15:0] b, input logic [15:0] c, input logic sub);
        int bi;
        int ci;
        int s;
        bi = $signed(b);
        ci = $signed(c);
        s  = sub ? (bi - ci) : (bi + ci);
        if (s > 32767)       return {1'b1, 16'h7FFF};
        else if (s < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, s[15:0]};
    endfunction

    // Single beat with checks on the 3-cycle latency, result and flag.
    task automatic vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic sub,
                       input logic [15:0] er, input logic es);
        in_a = a; in_b = b; in_c = c; in_sub = sub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_lat2"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_lat3"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"},  {16'd0, out_result}, {16'd0, er});
        chk({tag, "_sat"},  {31'd0, out_sat}, {31'd0, es});
        tick();
        chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 16'h0000; in_b = 16'h0000; in_c = 16'h0000; in_sub = 1'b0;
        hold_pend = 1'b0; hold_val = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("rst_res",    {16'd0, out_result}, 32'd0);
        chk("rst_sat",    {31'd0, out_sat}, 32'd0);
        chk("rst_inrdy",  {31'd0, in_ready}, 32'd1);

        // Directed arithmetic vectors
        vec("add",     16'h0100, 16'h0200, 16'h0080, 1'b0, 16'h0280, 1'b0);
        vec("sub",     16'h0100, 16'h0100, 16'h0200, 1'b1, 16'hFF00, 1'b0);
        vec("satpos",  16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 1'b1);
        vec("satneg",  16'h8000, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 1'b1);
        vec("maxedge", 16'h0100, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 1'b0);
        vec("minedge", 16'h0100, 16'h8000, 16'h0000, 1'b0, 16'h8000, 1'b0);
        vec("addovf",  16'h0100, 16'h7F00, 16'h0200, 1'b0, 16'h7FFF, 1'b1);
        vec("subovf",  16'h0000, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1);
`ifdef FX_MAC_ROUND_EN
        vec("rnd_pos", 16'h0001, 16'h0080, 16'h0000, 1'b0, 16'h0001, 1'b0);
        vec("rnd_neg", 16'hFFFF, 16'h0080, 16'h0000, 1'b0, 16'h0000, 1'b0);
`else
        vec("rnd_pos", 16'h0001, 16'h0080, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vec("rnd_neg", 16'hFFFF, 16'h0080, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
`endif

        // Backpressure: four beats with results 1..4 against a stalled output
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h0100; in_c = 16'h0000; in_sub = 1'b0;
        in_b = 16'h0001;
        #1;
        chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        in_b = 16'h0002;
        chk("bp_rdy2", {31'd0, in_ready}, 32'd1);
        tick();
        in_b = 16'h0003;
        chk("bp_rdy3", {31'd0, in_ready}, 32'd1);
        tick();
        in_b = 16'h0004;
        chk("bp_rdy_drop", {31'd0, in_ready}, 32'd0);
        chk("bp_ov1",  {31'd0, out_valid}, 32'd1);
        chk("bp_res1", {16'd0, out_result}, 32'd1);
        tick();
        chk("bp_rdy_hold", {31'd0, in_ready}, 32'd0);
        chk("bp_res1_hold", {16'd0, out_result}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_rise", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_res2", {16'd0, out_result}, 32'd2);
        tick();
        chk("bp_res3", {16'd0, out_result}, 32'd3);
        tick();
        chk("bp_res4", {16'd0, out_result}, 32'd4);
        chk("bp_ov4",  {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Random valid/ready toggling against a scoreboard
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_a      = 16'h0100;
            in_b      = 16'($urandom);
            in_c      = 16'($urandom);
            in_sub    = 1'($urandom_range(0, 1));
            #1;
            if (hold_pend) begin
                chk("rnd_hold_v", {31'd0, out_valid}, 32'd1);
                chk("rnd_hold_r", {16'd0, out_result}, {16'd0, hold_val});
            end
            hold_pend = out_valid & ~out_ready;
            hold_val  = out_result;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_b, in_c, in_sub));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("rnd_res", {16'd0, out_result}, {16'd0, exp_v[15:0]});
                    chk("rnd_sat", {31'd0, out_sat}, {31'd0, exp_v[16]});
                end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("drain_spurious", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("drain_res", {16'd0, out_result}, {16'd0, exp_v[15:0]});
                    chk("drain_sat", {31'd0, out_sat}, {31'd0, exp_v[16]});
                end
            end
            tick();
        end
        chk("drain_empty", exp_q.size(), 32'd0);

        // Reset with two beats in flight
        out_ready = 1'b1; in_valid = 1'b1;
        in_a = 16'h0100; in_b = 16'h0005; in_c = 16'h0000; in_sub = 1'b0;
        #1;
        tick();
        in_b = 16'h0006;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("mrst_res",    {16'd0, out_result}, 32'd0);
        chk("mrst_sat",    {31'd0, out_sat}, 32'd0);
        chk("mrst_inrdy",  {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mrst_stale", {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
